// File: rtl/kf_dma_bus_control_param_if.sv
// CPU-side bus pins of the KF DMA bus front-end: select, strobes, address,
// write data and the DMA bus-ownership lock.
interface kf_dma_bus_control_param_if #(
  parameter int ADDR_W = 4
) ();
  logic              chip_select_n;
  logic              io_read_n;
  logic              io_write_n;
  logic [ADDR_W-1:0] address;
  logic [7:0]        data_in;
  logic              lock_bus_control;

  modport master (
    output chip_select_n, io_read_n, io_write_n, address, data_in, lock_bus_control
  );

  modport slave (
    input chip_select_n, io_read_n, io_write_n, address, data_in, lock_bus_control
  );
endinterface

// File: rtl/kf_dma_bus_control_param.sv
// KF DMA bus front-end: turns CPU I/O accesses into one-cycle register strobes,
// owns the low/high byte pointer and defers a single write while the DMA holds the bus.
module kf_dma_bus_control_param #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  kf_dma_bus_control_param_if.slave bus,
  output logic [7:0]                internal_data_bus,
  output logic                      write_high_byte,
  output logic [NUM_CH-1:0]         write_address,
  output logic [NUM_CH-1:0]         write_count,
  output logic                      write_command,
  output logic                      write_request,
  output logic                      write_single_mask,
  output logic                      write_mode,
  output logic                      write_all_mask,
  output logic                      clear_byte_pointer,
  output logic                      master_clear,
  output logic                      clear_mask,
  output logic                      byte_pointer,
  output logic [NUM_CH-1:0]         read_address,
  output logic [NUM_CH-1:0]         read_count,
  output logic                      read_status,
  output logic                      read_temporary,
  output logic                      write_pending,
  output logic                      overrun
);
  localparam int CTRL_BASE = 2 ** (ADDR_W - 1);

  function automatic logic [NUM_CH-1:0] chan_dec(input logic [ADDR_W-1:0] a,
                                                 input logic count_reg);
    logic [NUM_CH-1:0] hit;
    for (int n = 0; n < NUM_CH; n++) begin
      hit[n] = (a[0] == count_reg) && (a[ADDR_W-1:1] == (ADDR_W-1)'(n));
    end
    return hit;
  endfunction

  function automatic logic chan_any(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(2 * NUM_CH);
  endfunction

  // Compared at 32 bits so offsets past the top of a narrow address space never alias.
  function automatic logic ctrl_hit(input logic [ADDR_W-1:0] a, input int off);
    return 32'(a) == 32'(CTRL_BASE + off);
  endfunction

  logic              lock_s;
  logic              wr_act_s, wr_act_r, wr_end_s;
  logic              rd_act_s, rd_act_r, rd_end_s;
  logic [ADDR_W-1:0] wr_addr_r, rd_addr_r, pend_addr_r, issue_addr_s;
  logic [7:0]        wr_data_r, pend_data_r, issue_data_s;
  logic              issue_s, store_s, drop_s;
  logic [NUM_CH-1:0] wa_next_s, wc_next_s;
  logic [7:0]        ctrl_next_s;
  logic              ch_wr_s, rd_tog_s, bp_next_s, ov_next_s;
  logic              rd_live_s;

  assign lock_s    = bus.lock_bus_control;
  assign wr_act_s  = ~bus.chip_select_n & ~bus.io_write_n;
  assign rd_act_s  = ~bus.chip_select_n & ~bus.io_read_n;
  assign wr_end_s  = wr_act_r & ~wr_act_s;
  assign rd_end_s  = rd_act_r & ~rd_act_s;
  assign rd_live_s = rd_act_s & ~lock_s & ~reset;

  // Choose what to issue: a held write always wins over a newly ended one, which is then dropped.
  always_comb begin
    issue_s      = 1'b0;
    store_s      = 1'b0;
    drop_s       = 1'b0;
    issue_addr_s = wr_addr_r;
    issue_data_s = wr_data_r;
    if (write_pending) begin
      drop_s       = wr_end_s;
      issue_s      = ~lock_s;
      issue_addr_s = pend_addr_r;
      issue_data_s = pend_data_r;
    end else begin
      issue_s = wr_end_s & ~lock_s;
      store_s = wr_end_s & lock_s;
    end
  end

  // Decode the issued address into next-cycle strobes.
  always_comb begin
    wa_next_s   = '0;
    wc_next_s   = '0;
    ctrl_next_s = 8'h00;
    ch_wr_s     = 1'b0;
    if (issue_s) begin
      wa_next_s = chan_dec(issue_addr_s, 1'b0);
      wc_next_s = chan_dec(issue_addr_s, 1'b1);
      ch_wr_s   = chan_any(issue_addr_s);
      for (int k = 0; k < 8; k++) begin
        ctrl_next_s[k] = ctrl_hit(issue_addr_s, k);
      end
    end else begin
      ch_wr_s = 1'b0;
    end
  end

  // Byte pointer and overrun next state; clears override toggles, XOR cancels a double toggle.
  always_comb begin
    rd_tog_s  = rd_end_s & ~lock_s & chan_any(rd_addr_r);
    bp_next_s = byte_pointer;
    ov_next_s = overrun;
    if (ctrl_next_s[4] | ctrl_next_s[5]) begin
      bp_next_s = 1'b0;
    end else begin
      bp_next_s = byte_pointer ^ ch_wr_s ^ rd_tog_s;
    end
    if (drop_s) begin
      ov_next_s = 1'b1;
    end else if (ctrl_next_s[5]) begin
      ov_next_s = 1'b0;
    end else begin
      ov_next_s = overrun;
    end
  end

  // Access capture, deferred-write holding register and pointer/overrun state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_act_r          <= 1'b0;
      rd_act_r          <= 1'b0;
      wr_addr_r         <= '0;
      wr_data_r         <= 8'h00;
      rd_addr_r         <= '0;
      pend_addr_r       <= '0;
      pend_data_r       <= 8'h00;
      write_pending     <= 1'b0;
      byte_pointer      <= 1'b0;
      overrun           <= 1'b0;
      internal_data_bus <= 8'h00;
    end else begin
      wr_act_r <= wr_act_s;
      rd_act_r <= rd_act_s;
      if (wr_act_s) begin
        wr_addr_r <= bus.address;
        wr_data_r <= bus.data_in;
      end
      if (rd_act_s) begin
        rd_addr_r <= bus.address;
      end
      if (store_s) begin
        pend_addr_r <= wr_addr_r;
        pend_data_r <= wr_data_r;
      end
      write_pending <= store_s | (write_pending & ~issue_s);
      byte_pointer  <= bp_next_s;
      overrun       <= ov_next_s;
      if (issue_s) begin
        internal_data_bus <= issue_data_s;
      end
    end
  end

  // One-cycle write strobes, registered from the issue decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_address      <= '0;
      write_count        <= '0;
      write_command      <= 1'b0;
      write_request      <= 1'b0;
      write_single_mask  <= 1'b0;
      write_mode         <= 1'b0;
      clear_byte_pointer <= 1'b0;
      master_clear       <= 1'b0;
      clear_mask         <= 1'b0;
      write_all_mask     <= 1'b0;
      write_high_byte    <= 1'b0;
    end else begin
      write_address      <= wa_next_s;
      write_count        <= wc_next_s;
      write_command      <= ctrl_next_s[0];
      write_request      <= ctrl_next_s[1];
      write_single_mask  <= ctrl_next_s[2];
      write_mode         <= ctrl_next_s[3];
      clear_byte_pointer <= ctrl_next_s[4];
      master_clear       <= ctrl_next_s[5];
      clear_mask         <= ctrl_next_s[6];
      write_all_mask     <= ctrl_next_s[7];
      write_high_byte    <= ch_wr_s & byte_pointer;
    end
  end

  // Read selects follow the live bus; the lock blocks them outright.
  always_comb begin
    if (rd_live_s) begin
      read_address   = chan_dec(bus.address, 1'b0);
      read_count     = chan_dec(bus.address, 1'b1);
      read_status    = ctrl_hit(bus.address, 0);
      read_temporary = ctrl_hit(bus.address, 5);
    end else begin
      read_address   = '0;
      read_count     = '0;
      read_status    = 1'b0;
      read_temporary = 1'b0;
    end
  end
endmodule

// File: tb/tb_kf_dma_bus_control_param.sv
// Scoreboard bench for kf_dma_bus_control_param: a transaction-level model predicts
// every strobe (identity, data, high byte, cycle) and a negedge monitor checks them.
module tb_kf_dma_bus_control_param;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int failures = 0;

  kf_dma_bus_control_param_if #(.ADDR_W(4)) bus4 ();
  kf_dma_bus_control_param_if #(.ADDR_W(5)) bus5 ();

  // Main DUT, NUM_CH=4 ADDR_W=4
  logic [7:0] idb;
  logic       whb, wcmd, wreq, wsm, wmode, wall, cbp, mclr, cmask, bp, rstat, rtemp, wpend, ovr;
  logic [3:0] wa, wc, ra, rc;

  kf_dma_bus_control_param #(.NUM_CH(4), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .bus(bus4),
    .internal_data_bus(idb), .write_high_byte(whb), .write_address(wa), .write_count(wc),
    .write_command(wcmd), .write_request(wreq), .write_single_mask(wsm), .write_mode(wmode),
    .write_all_mask(wall), .clear_byte_pointer(cbp), .master_clear(mclr), .clear_mask(cmask),
    .byte_pointer(bp), .read_address(ra), .read_count(rc), .read_status(rstat),
    .read_temporary(rtemp), .write_pending(wpend), .overrun(ovr)
  );

  // NUM_CH=2 ADDR_W=4 on the same bus
  logic [7:0] d2_idb;
  logic       d2_whb, d2_wcmd, d2_wreq, d2_wsm, d2_wmode, d2_wall, d2_cbp, d2_mclr, d2_cmask;
  logic       d2_bp, d2_rstat, d2_rtemp, d2_wpend, d2_ovr;
  logic [1:0] d2_wa, d2_wc, d2_ra, d2_rc;

  kf_dma_bus_control_param #(.NUM_CH(2), .ADDR_W(4)) dut2 (
    .clock(clock), .reset(reset), .bus(bus4),
    .internal_data_bus(d2_idb), .write_high_byte(d2_whb), .write_address(d2_wa),
    .write_count(d2_wc), .write_command(d2_wcmd), .write_request(d2_wreq),
    .write_single_mask(d2_wsm), .write_mode(d2_wmode), .write_all_mask(d2_wall),
    .clear_byte_pointer(d2_cbp), .master_clear(d2_mclr), .clear_mask(d2_cmask),
    .byte_pointer(d2_bp), .read_address(d2_ra), .read_count(d2_rc), .read_status(d2_rstat),
    .read_temporary(d2_rtemp), .write_pending(d2_wpend), .overrun(d2_ovr)
  );

  // NUM_CH=8 ADDR_W=5 on its own bus
  logic [7:0] d8_idb;
  logic       d8_whb, d8_wcmd, d8_wreq, d8_wsm, d8_wmode, d8_wall, d8_cbp, d8_mclr, d8_cmask;
  logic       d8_bp, d8_rstat, d8_rtemp, d8_wpend, d8_ovr;
  logic [7:0] d8_wa, d8_wc, d8_ra, d8_rc;

  kf_dma_bus_control_param #(.NUM_CH(8), .ADDR_W(5)) dut8 (
    .clock(clock), .reset(reset), .bus(bus5),
    .internal_data_bus(d8_idb), .write_high_byte(d8_whb), .write_address(d8_wa),
    .write_count(d8_wc), .write_command(d8_wcmd), .write_request(d8_wreq),
    .write_single_mask(d8_wsm), .write_mode(d8_wmode), .write_all_mask(d8_wall),
    .clear_byte_pointer(d8_cbp), .master_clear(d8_mclr), .clear_mask(d8_cmask),
    .byte_pointer(d8_bp), .read_address(d8_ra), .read_count(d8_rc), .read_status(d8_rstat),
    .read_temporary(d8_rtemp), .write_pending(d8_wpend), .overrun(d8_ovr)
  );

  typedef struct {
    int id;
    int data;
    int hb;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state (main DUT)
  int m_bp = 0, m_pend = 0, m_pa = 0, m_pd = 0, m_ov = 0, m_last = 0, m_lock = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe id = register address: channels 0..7, control 8..15.
  task automatic m_issue(input int a, input int d, input int c);
    exp_t e;
    e.id = a; e.data = d; e.cyc = c; e.hb = 0;
    m_last = d;
    if (a < 8) begin
      e.hb = m_bp;
      m_bp = m_bp ^ 1;
    end else begin
      if (a == 12 || a == 13) m_bp = 0;
      if (a == 13) m_ov = 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic m_write_end(input int a, input int d, input int c);
    if (m_pend != 0) m_ov = 1;
    else if (m_lock != 0) begin
      m_pend = 1; m_pa = a; m_pd = d;
    end else m_issue(a, d, c + 1);
  endtask

  task automatic chk_state();
    chk("byte_pointer", bp, m_bp);
    chk("write_pending", wpend, m_pend);
    chk("overrun", ovr, m_ov);
    chk("internal_data_bus", idb, m_last);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic wr(input int a, input int d, input int hold);
    @(negedge clock);
    bus4.address = 4'(a); bus4.data_in = 8'(d);
    bus4.chip_select_n = 1'b0; bus4.io_write_n = 1'b0;
    repeat (hold) @(negedge clock);
    bus4.io_write_n = 1'b1; bus4.chip_select_n = 1'b1;
    m_write_end(a, d, cyc);
    repeat (2) @(negedge clock);
    chk_state();
  endtask

  task automatic rd(input int a, input int hold);
    int ea, ec, es, et;
    @(negedge clock);
    bus4.address = 4'(a);
    bus4.chip_select_n = 1'b0; bus4.io_read_n = 1'b0;
    @(negedge clock);
    ea = (m_lock == 0 && a < 8 && a % 2 == 0) ? (1 << (a / 2)) : 0;
    ec = (m_lock == 0 && a < 8 && a % 2 == 1) ? (1 << (a / 2)) : 0;
    es = (m_lock == 0 && a == 8) ? 1 : 0;
    et = (m_lock == 0 && a == 13) ? 1 : 0;
    chk("read_address", ra, ea);
    chk("read_count", rc, ec);
    chk("read_status", rstat, es);
    chk("read_temporary", rtemp, et);
    repeat (hold - 1) @(negedge clock);
    bus4.io_read_n = 1'b1; bus4.chip_select_n = 1'b1;
    if (m_lock == 0 && a < 8) m_bp = m_bp ^ 1;
    repeat (2) @(negedge clock);
    chk_state();
  endtask

  task automatic set_lock(input int v);
    @(negedge clock);
    bus4.lock_bus_control = v[0];
    m_lock = v;
    if (v == 0 && m_pend != 0) begin
      m_pend = 0;
      m_issue(m_pa, m_pd, cyc + 1);
    end
    repeat (2) @(negedge clock);
    chk_state();
  endtask

  task automatic wr5(input int a, input int d);
    @(negedge clock);
    bus5.address = 5'(a); bus5.data_in = 8'(d);
    bus5.chip_select_n = 1'b0; bus5.io_write_n = 1'b0;
    @(negedge clock);
    bus5.io_write_n = 1'b1; bus5.chip_select_n = 1'b1;
    @(negedge clock);
  endtask

  // Monitor: every strobe cycle pops one expectation.
  always @(negedge clock) begin
    if (!reset) begin
      int id, n;
      logic [7:0] ctl;
      exp_t e;
      id = -1; n = 0;
      ctl = {wall, cmask, mclr, cbp, wmode, wsm, wreq, wcmd};
      for (int i = 0; i < 4; i++) begin
        if (wa[i]) begin id = 2 * i; n++; end
        if (wc[i]) begin id = 2 * i + 1; n++; end
      end
      for (int k = 0; k < 8; k++) begin
        if (ctl[k]) begin id = 8 + k; n++; end
      end
      if (n > 1) chk("strobe_one_hot", n, 1);
      if (n >= 1) begin
        if (exp_q.size() == 0) chk("unexpected_strobe", id, -1);
        else begin
          e = exp_q.pop_front();
          chk("strobe_id", id, e.id);
          chk("strobe_data", idb, e.data);
          chk("strobe_cycle", cyc, e.cyc);
          if (e.id < 8) chk("write_high_byte", whb, e.hb);
        end
      end
    end
  end

  // Sticky record of NUM_CH=2 strobes for the out-of-map check.
  logic [11:0] d2_seen;
  always @(negedge clock) begin
    if (!reset) d2_seen = d2_seen | {d2_wa, d2_wc, d2_wall, d2_cmask, d2_mclr, d2_cbp,
                                     d2_wmode, d2_wsm, d2_wreq, d2_wcmd};
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, saved_bp;
    d2_seen = 12'h000;
    bus4.chip_select_n = 1'b1; bus4.io_read_n = 1'b1; bus4.io_write_n = 1'b1;
    bus4.address = 4'h0; bus4.data_in = 8'h00; bus4.lock_bus_control = 1'b0;
    bus5.chip_select_n = 1'b1; bus5.io_read_n = 1'b1; bus5.io_write_n = 1'b1;
    bus5.address = 5'h00; bus5.data_in = 8'h00; bus5.lock_bus_control = 1'b0;

    repeat (3) @(negedge clock);
    chk("reset_strobes", {wa, wc, wcmd, wreq, wsm, wmode, wall, cbp, mclr, cmask, whb}, 0);
    chk("reset_state", {idb, bp, wpend, ovr}, 0);
    reset = 1'b0;
    @(negedge clock);

    // Two writes to channel 1 address register, then clear pointer and a read
    wr(2, 8'h34, 1);
    wr(2, 8'h12, 2);
    wr(0, 8'h55, 1);
    wr(12, 8'h00, 1);
    rd(1, 2);
    rd(8, 1);
    // Deferred mode write
    set_lock(1);
    wr(11, 8'h5A, 1);
    rd(0, 1);
    set_lock(0);
    // Held command, dropped all-mask, then master clear
    set_lock(1);
    wr(8, 8'hA1, 1);
    wr(15, 8'hFF, 2);
    set_lock(0);
    wr(13, 8'h00, 1);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) wr($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(1, 3));
      else if (op <= 8) rd($urandom_range(0, 15), $urandom_range(1, 3));
      else set_lock(m_lock ^ 1);
    end
    set_lock(0);

    // NUM_CH=2: address 6 is unmapped, address 2 is channel 1
    saved_bp = d2_bp;
    d2_seen = 12'h000;
    wr(6, 8'h66, 1);
    chk("d2_unmapped_no_strobe", d2_seen, 0);
    chk("d2_unmapped_bp", d2_bp, saved_bp);
    d2_seen = 12'h000;
    wr(2, 8'h22, 1);
    chk("d2_chan1_strobe", d2_seen, 12'h800);
    chk("d2_chan1_bp", d2_bp, saved_bp ^ 1);

    // NUM_CH=8, ADDR_W=5
    wr5(15, 8'h77);
    chk("d8_write_count7", {d8_wc, d8_wa, d8_wcmd}, {8'h80, 8'h00, 1'b0});
    chk("d8_bus", d8_idb, 8'h77);
    wr5(16, 8'h11);
    chk("d8_write_command", {d8_wc, d8_wa, d8_wcmd}, {8'h00, 8'h00, 1'b1});
    wr5(24, 8'h99);
    chk("d8_unmapped", {d8_wc, d8_wa, d8_wcmd, d8_wreq, d8_wsm, d8_wmode, d8_wall,
                        d8_cbp, d8_mclr, d8_cmask}, 0);
    chk("d8_bp", d8_bp, 1);

    // Reset mid-write with a held write, pointer set and overrun set
    wr(0, 8'h01, 1);
    set_lock(1);
    wr(1, 8'h02, 1);
    wr(2, 8'h03, 1);
    @(negedge clock);
    bus4.address = 4'h3; bus4.data_in = 8'hC3;
    bus4.chip_select_n = 1'b0; bus4.io_write_n = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_strobes", {wa, wc, wcmd, wreq, wsm, wmode, wall, cbp, mclr, cmask, whb}, 0);
    chk("async_reset_state", {idb, bp, wpend, ovr}, 0);
    m_bp = 0; m_pend = 0; m_ov = 0; m_last = 0;
    exp_q.delete();
    bus4.lock_bus_control = 1'b0; m_lock = 0;
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_state();
    bus4.io_write_n = 1'b1; bus4.chip_select_n = 1'b1;
    m_write_end(3, 8'hC3, cyc);
    repeat (2) @(negedge clock);
    chk_state();

    repeat (2) @(negedge clock);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
